// File: rtl/ladybird_alu_mmu_pkg.sv
// ladybird shared configuration: datapath width, opcode/funct3 constants
// and the FSM state types used by the execute/memory block.
package ladybird_config;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        I_IDLE,
        I_REQ,
        I_WAIT
    } ifetch_state_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_REQ,
        D_WAIT,
        D_RESP
    } dmem_state_e;

endpackage

// File: rtl/ladybird_alu_mmu_alu.sv
// ladybird integer ALU: RV32I reg/imm arithmetic, logic, shift, compare.
// The adder is either behavioural or a ripple chain of full adders.
module ladybird_alu #(
    parameter int XLEN          = 32,
    parameter bit USE_FA_MODULE = 1'b0
) (
    input  logic [2:0]      op,
    input  logic            alt,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic [XLEN-1:0] q
);
    import ladybird_config::*;

    logic [XLEN-1:0] b_in;
    logic [XLEN-1:0] sum;
    logic [4:0]      shamt;

    // Subtract as a + ~b + 1, carry-in comes from alt
    assign b_in  = alt ? ~src2 : src2;
    assign shamt = src2[4:0];

    generate
        if (USE_FA_MODULE) begin : g_fa
            logic [XLEN-1:0] c;
            assign c[0] = alt;
            for (genvar i = 0; i < XLEN; i++) begin : g_bit
                assign sum[i] = src1[i] ^ b_in[i] ^ c[i];
                if (i < XLEN - 1) begin : g_carry
                    assign c[i+1] = (src1[i] & b_in[i])
                                  | (c[i] & (src1[i] ^ b_in[i]));
                end
            end
        end else begin : g_beh
            assign sum = src1 + b_in + {{(XLEN-1){1'b0}}, alt};
        end
    endgenerate

    always_comb begin
        q = '0;
        unique case (op)
            F3_ADD:  q = sum;
            F3_SLL:  q = src1 << shamt;
            F3_SLT:  q = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            F3_SLTU: q = {{(XLEN-1){1'b0}}, src1 < src2};
            F3_XOR:  q = src1 ^ src2;
            F3_SR:   q = alt ? $unsigned($signed(src1) >>> shamt)
                             : src1 >> shamt;
            F3_OR:   q = src1 | src2;
            F3_AND:  q = src1 & src2;
        endcase
    end

endmodule

// File: rtl/ladybird_alu_mmu.sv
// ladybird execute/memory block: combinational ALU plus an MMU with an
// instruction-fetch FSM and a load/store FSM on separate buses.
module ladybird_alu_mmu #(
    parameter int XLEN          = 32,
    parameter bit USE_FA_MODULE = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      alu_op,
    input  logic            alu_alt,
    input  logic [XLEN-1:0] alu_src1,
    input  logic [XLEN-1:0] alu_src2,
    output logic [XLEN-1:0] alu_q,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_data,
    input  logic            i_we,
    input  logic [2:0]      i_funct,
    output logic            o_valid,
    output logic [XLEN-1:0] o_data,
    input  logic            o_ready,
    input  logic [XLEN-1:0] pc,
    input  logic            pc_valid,
    output logic            pc_ready,
    output logic [31:0]     inst,
    output logic            inst_valid,
    output logic            ibus_req_valid,
    input  logic            ibus_req_ready,
    output logic [XLEN-1:0] ibus_addr,
    input  logic            ibus_resp_valid,
    input  logic [31:0]     ibus_resp_data,
    output logic            dbus_req_valid,
    input  logic            dbus_req_ready,
    output logic [XLEN-1:0] dbus_addr,
    output logic            dbus_we,
    output logic [3:0]      dbus_strb,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_resp_valid,
    input  logic [XLEN-1:0] dbus_resp_data
);
    import ladybird_config::*;

    ladybird_alu #(
        .XLEN          (XLEN),
        .USE_FA_MODULE (USE_FA_MODULE)
    ) u_alu (
        .op   (alu_op),
        .alt  (alu_alt),
        .src1 (alu_src1),
        .src2 (alu_src2),
        .q    (alu_q)
    );

    ifetch_state_e i_state, i_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            i_state    <= I_IDLE;
            inst       <= '0;
            inst_valid <= 1'b0;
        end else begin
            i_state    <= i_next;
            inst_valid <= 1'b0;
            if (i_state == I_WAIT && ibus_resp_valid) begin
                inst       <= ibus_resp_data;
                inst_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        i_next         = i_state;
        pc_ready       = 1'b0;
        ibus_req_valid = 1'b0;
        case (i_state)
            I_IDLE: begin
                pc_ready       = ibus_req_ready;
                ibus_req_valid = pc_valid;
                if (pc_valid && ibus_req_ready)
                    i_next = I_WAIT;
            end
            I_WAIT: if (ibus_resp_valid) i_next = I_IDLE;
            default: i_next = I_IDLE;
        endcase
    end

    assign ibus_addr = {pc[XLEN-1:2], 2'b00};

    dmem_state_e     d_state, d_next;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_we;
    logic [2:0]      d_funct;
    logic [7:0]      lb;
    logic [15:0]     lh;
    logic [XLEN-1:0] load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_state <= D_IDLE;
            d_addr  <= '0;
            d_wdata <= '0;
            d_we    <= 1'b0;
            d_funct <= '0;
            o_data  <= '0;
        end else begin
            d_state <= d_next;
            if (d_state == D_IDLE && i_valid) begin
                d_addr  <= i_addr;
                d_wdata <= i_data;
                d_we    <= i_we;
                d_funct <= i_funct;
            end
            if (d_state == D_WAIT && dbus_resp_valid)
                o_data <= d_we ? '0 : load_val;
        end
    end

    always_comb begin
        d_next         = d_state;
        i_ready        = 1'b0;
        dbus_req_valid = 1'b0;
        o_valid        = 1'b0;
        case (d_state)
            D_IDLE: begin
                i_ready = 1'b1;
                if (i_valid) d_next = D_REQ;
            end
            D_REQ: begin
                dbus_req_valid = 1'b1;
                if (dbus_req_ready) d_next = D_WAIT;
            end
            D_WAIT: if (dbus_resp_valid) d_next = D_RESP;
            D_RESP: begin
                o_valid = 1'b1;
                if (o_ready) d_next = D_IDLE;
            end
            default: d_next = D_IDLE;
        endcase
    end

    assign dbus_addr = {d_addr[XLEN-1:2], 2'b00};
    assign dbus_we   = d_we;

    // Width comes from funct[1:0]; undefined encodings fall to word
    always_comb begin
        dbus_strb  = 4'b1111;
        dbus_wdata = d_wdata;
        case (d_funct[1:0])
            2'b00: begin
                dbus_wdata = {(XLEN/8){d_wdata[7:0]}};
                if (d_we) dbus_strb = 4'b0001 << d_addr[1:0];
            end
            2'b01: begin
                dbus_wdata = {(XLEN/16){d_wdata[15:0]}};
                if (d_we) dbus_strb = 4'b0011 << {d_addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        lb       = dbus_resp_data[{d_addr[1:0], 3'b000} +: 8];
        lh       = d_addr[1] ? dbus_resp_data[31:16] : dbus_resp_data[15:0];
        load_val = dbus_resp_data;
        case (d_funct)
            F3_B:  load_val = {{(XLEN-8){lb[7]}}, lb};
            F3_BU: load_val = {{(XLEN-8){1'b0}}, lb};
            F3_H:  load_val = {{(XLEN-16){lh[15]}}, lh};
            F3_HU: load_val = {{(XLEN-16){1'b0}}, lh};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ladybird_alu_mmu.sv
// Directed bench for ladybird_alu_mmu: ALU and load/store vector tables
// plus hand-written fetch, back-pressure and reset sequences.
module tb_ladybird_alu_mmu;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  alu_op;
    logic        alu_alt;
    logic [31:0] alu_src1, alu_src2, alu_q;
    logic        i_valid, i_ready;
    logic [31:0] i_addr, i_data;
    logic        i_we;
    logic [2:0]  i_funct;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_ready;
    logic [31:0] pc;
    logic        pc_valid, pc_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        ibus_req_valid, ibus_req_ready;
    logic [31:0] ibus_addr;
    logic        ibus_resp_valid;
    logic [31:0] ibus_resp_data;
    logic        dbus_req_valid, dbus_req_ready;
    logic [31:0] dbus_addr;
    logic        dbus_we;
    logic [3:0]  dbus_strb;
    logic [31:0] dbus_wdata;
    logic        dbus_resp_valid;
    logic [31:0] dbus_resp_data;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ladybird_alu_mmu #(.XLEN(32), .USE_FA_MODULE(1'b0)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_op          (alu_op),
        .alu_alt         (alu_alt),
        .alu_src1        (alu_src1),
        .alu_src2        (alu_src2),
        .alu_q           (alu_q),
        .i_valid         (i_valid),
        .i_ready         (i_ready),
        .i_addr          (i_addr),
        .i_data          (i_data),
        .i_we            (i_we),
        .i_funct         (i_funct),
        .o_valid         (o_valid),
        .o_data          (o_data),
        .o_ready         (o_ready),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .pc_ready        (pc_ready),
        .inst            (inst),
        .inst_valid      (inst_valid),
        .ibus_req_valid  (ibus_req_valid),
        .ibus_req_ready  (ibus_req_ready),
        .ibus_addr       (ibus_addr),
        .ibus_resp_valid (ibus_resp_valid),
        .ibus_resp_data  (ibus_resp_data),
        .dbus_req_valid  (dbus_req_valid),
        .dbus_req_ready  (dbus_req_ready),
        .dbus_addr       (dbus_addr),
        .dbus_we         (dbus_we),
        .dbus_strb       (dbus_strb),
        .dbus_wdata      (dbus_wdata),
        .dbus_resp_valid (dbus_resp_valid),
        .dbus_resp_data  (dbus_resp_data)
    );

    typedef struct {
        logic [2:0]  op;
        logic        alt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
    } alu_vec_t;

    typedef struct {
        logic        we;
        logic [2:0]  funct;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mem;
        logic [31:0] x_addr;
        logic [3:0]  x_strb;
        logic [31:0] x_wdata;
        logic [31:0] x_odata;
    } mem_vec_t;

    alu_vec_t av[14];
    mem_vec_t mv[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic run_mem(input int k);
        @(negedge clk);
        i_valid = 1'b1;
        i_we    = mv[k].we;
        i_funct = mv[k].funct;
        i_addr  = mv[k].addr;
        i_data  = mv[k].wd;
        #1 chk($sformatf("mv%0d i_ready", k), 32'(i_ready), 32'd1);
        @(negedge clk);
        i_valid        = 1'b0;
        dbus_req_ready = 1'b1;
        #1;
        chk($sformatf("mv%0d req_valid", k), 32'(dbus_req_valid), 32'd1);
        chk($sformatf("mv%0d addr", k), dbus_addr, mv[k].x_addr);
        chk($sformatf("mv%0d we", k), 32'(dbus_we), 32'(mv[k].we));
        chk($sformatf("mv%0d strb", k), 32'(dbus_strb), 32'(mv[k].x_strb));
        if (mv[k].we)
            chk($sformatf("mv%0d wdata", k), dbus_wdata, mv[k].x_wdata);
        @(negedge clk);
        dbus_req_ready  = 1'b0;
        dbus_resp_valid = 1'b1;
        dbus_resp_data  = mv[k].mem;
        #1 chk($sformatf("mv%0d early o_valid", k), 32'(o_valid), 32'd0);
        @(negedge clk);
        dbus_resp_valid = 1'b0;
        o_ready         = 1'b1;
        #1;
        chk($sformatf("mv%0d o_valid", k), 32'(o_valid), 32'd1);
        chk($sformatf("mv%0d o_data", k), o_data, mv[k].x_odata);
        @(negedge clk);
        o_ready = 1'b0;
        #1 chk($sformatf("mv%0d idle", k), 32'(i_ready), 32'd1);
    endtask

    initial begin
        av[0]  = '{3'b000, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
        av[1]  = '{3'b000, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
        av[2]  = '{3'b101, 1'b1, 32'h80000000, 32'h00000004, 32'hF8000000};
        av[3]  = '{3'b010, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        av[4]  = '{3'b011, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        av[5]  = '{3'b101, 1'b0, 32'h80000000, 32'h00000004, 32'h08000000};
        av[6]  = '{3'b001, 1'b0, 32'h00000001, 32'h0000001F, 32'h80000000};
        av[7]  = '{3'b001, 1'b1, 32'h00000001, 32'h00000024, 32'h00000010};
        av[8]  = '{3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
        av[9]  = '{3'b110, 1'b1, 32'h00000F00, 32'h000000F0, 32'h00000FF0};
        av[10] = '{3'b111, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00};
        av[11] = '{3'b010, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        av[12] = '{3'b000, 1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
        av[13] = '{3'b000, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};

        mv[0]  = '{1'b1, 3'b000, 32'h00001003, 32'h000000AB, 32'h0,
                   32'h00001000, 4'h8, 32'hABABABAB, 32'h0};
        mv[1]  = '{1'b1, 3'b001, 32'h00001002, 32'h1234BEEF, 32'h0,
                   32'h00001000, 4'hC, 32'hBEEFBEEF, 32'h0};
        mv[2]  = '{1'b1, 3'b001, 32'h00001001, 32'h00005A5A, 32'h0,
                   32'h00001000, 4'h3, 32'h5A5A5A5A, 32'h0};
        mv[3]  = '{1'b1, 3'b010, 32'h00001001, 32'hDEADBEEF, 32'h0,
                   32'h00001000, 4'hF, 32'hDEADBEEF, 32'h0};
        mv[4]  = '{1'b0, 3'b000, 32'h00002001, 32'h0, 32'h80FF7F01,
                   32'h00002000, 4'hF, 32'h0, 32'h0000007F};
        mv[5]  = '{1'b0, 3'b000, 32'h00002002, 32'h0, 32'h80FF7F01,
                   32'h00002000, 4'hF, 32'h0, 32'hFFFFFFFF};
        mv[6]  = '{1'b0, 3'b100, 32'h00002002, 32'h0, 32'h80FF7F01,
                   32'h00002000, 4'hF, 32'h0, 32'h000000FF};
        mv[7]  = '{1'b0, 3'b001, 32'h00002002, 32'h0, 32'h80FF7F01,
                   32'h00002000, 4'hF, 32'h0, 32'hFFFF80FF};
        mv[8]  = '{1'b0, 3'b101, 32'h00002000, 32'h0, 32'h80FF7F01,
                   32'h00002000, 4'hF, 32'h0, 32'h00007F01};
        mv[9]  = '{1'b0, 3'b010, 32'h00002003, 32'h0, 32'h80FF7F01,
                   32'h00002000, 4'hF, 32'h0, 32'h80FF7F01};
        mv[10] = '{1'b0, 3'b001, 32'h00002003, 32'h0, 32'h80FF7F01,
                   32'h00002000, 4'hF, 32'h0, 32'hFFFF80FF};
        mv[11] = '{1'b0, 3'b111, 32'h00002000, 32'h0, 32'h80FF7F01,
                   32'h00002000, 4'hF, 32'h0, 32'h80FF7F01};

        rst = 1'b1;
        alu_op = '0; alu_alt = 1'b0; alu_src1 = '0; alu_src2 = '0;
        i_valid = 1'b0; i_addr = '0; i_data = '0; i_we = 1'b0;
        i_funct = '0; o_ready = 1'b0;
        pc = '0; pc_valid = 1'b0; ibus_req_ready = 1'b0;
        ibus_resp_valid = 1'b0; ibus_resp_data = '0;
        dbus_req_ready = 1'b0; dbus_resp_valid = 1'b0; dbus_resp_data = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst i_ready", 32'(i_ready), 32'd1);
        chk("rst o_valid", 32'(o_valid), 32'd0);
        chk("rst o_data", o_data, 32'd0);
        chk("rst inst", inst, 32'd0);
        chk("rst inst_valid", 32'(inst_valid), 32'd0);
        chk("rst dbus_req_valid", 32'(dbus_req_valid), 32'd0);
        chk("rst ibus_req_valid", 32'(ibus_req_valid), 32'd0);

        for (int k = 0; k < 14; k++) begin
            alu_op   = av[k].op;
            alu_alt  = av[k].alt;
            alu_src1 = av[k].a;
            alu_src2 = av[k].b;
            #1 chk($sformatf("alu%0d", k), alu_q, av[k].q);
        end

        for (int k = 0; k < 12; k++) run_mem(k);

        // fetch with ibus_req_ready held low for three cycles
        @(negedge clk);
        pc = 32'h00002006;
        pc_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("fetch pc_ready low", 32'(pc_ready), 32'd0);
            chk("fetch req_valid", 32'(ibus_req_valid), 32'd1);
            chk("fetch addr", ibus_addr, 32'h00002004);
            @(negedge clk);
        end
        ibus_req_ready = 1'b1;
        #1 chk("fetch pc_ready", 32'(pc_ready), 32'd1);
        @(negedge clk);
        pc_valid = 1'b0;
        ibus_resp_valid = 1'b1;
        ibus_resp_data = 32'hCAFEF00D;
        #1;
        chk("fetch wait pc_ready", 32'(pc_ready), 32'd0);
        chk("fetch early inst_valid", 32'(inst_valid), 32'd0);
        @(negedge clk);
        ibus_resp_valid = 1'b0;
        ibus_req_ready = 1'b0;
        #1;
        chk("fetch inst_valid", 32'(inst_valid), 32'd1);
        chk("fetch inst", inst, 32'hCAFEF00D);
        @(negedge clk);
        #1;
        chk("fetch pulse end", 32'(inst_valid), 32'd0);
        chk("fetch inst hold", inst, 32'hCAFEF00D);

        // dbus and completion back-pressure, with a stray request
        @(negedge clk);
        i_valid = 1'b1; i_we = 1'b0; i_funct = 3'b001;
        i_addr = 32'h00003006; i_data = '0;
        #1 chk("bp accept", 32'(i_ready), 32'd1);
        @(negedge clk);
        i_addr = 32'h00009000; i_we = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp req_valid", 32'(dbus_req_valid), 32'd1);
            chk("bp i_ready", 32'(i_ready), 32'd0);
            chk("bp addr", dbus_addr, 32'h00003004);
            chk("bp we", 32'(dbus_we), 32'd0);
            @(negedge clk);
        end
        i_valid = 1'b0;
        dbus_req_ready = 1'b1;
        #1 chk("bp req_valid last", 32'(dbus_req_valid), 32'd1);
        @(negedge clk);
        dbus_req_ready = 1'b0;
        dbus_resp_valid = 1'b1;
        dbus_resp_data = 32'hBEEF0000;
        @(negedge clk);
        dbus_resp_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("bp o_valid", 32'(o_valid), 32'd1);
            chk("bp o_data", o_data, 32'hFFFFBEEF);
            chk("bp i_ready busy", 32'(i_ready), 32'd0);
            @(negedge clk);
        end
        o_ready = 1'b1;
        #1 chk("bp o_valid held", 32'(o_valid), 32'd1);
        @(negedge clk);
        o_ready = 1'b0;
        #1;
        chk("bp done o_valid", 32'(o_valid), 32'd0);
        chk("bp done i_ready", 32'(i_ready), 32'd1);

        // reset while waiting for the dbus response
        @(negedge clk);
        i_valid = 1'b1; i_we = 1'b0; i_funct = 3'b010;
        i_addr = 32'h00000040;
        @(negedge clk);
        i_valid = 1'b0;
        dbus_req_ready = 1'b1;
        @(negedge clk);
        dbus_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstw o_valid", 32'(o_valid), 32'd0);
        chk("rstw i_ready", 32'(i_ready), 32'd1);
        chk("rstw req_valid", 32'(dbus_req_valid), 32'd0);
        @(negedge clk);
        dbus_resp_valid = 1'b1;
        dbus_resp_data = 32'h12345678;
        @(negedge clk);
        dbus_resp_valid = 1'b0;
        #1;
        chk("stray o_valid", 32'(o_valid), 32'd0);
        chk("stray o_data", o_data, 32'd0);
        chk("stray i_ready", 32'(i_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
